// File: rtl/mouse_master_sm.sv
// PS/2 mouse host controller: power-up handshake (0xFF reset, 0xFA/0xAA/0x00,
// 0xF4 enable, 0xFA) followed by 3-byte movement packet parsing with a
// one-cycle interrupt per packet.
// Optional build macro MOUSE_RESP_TIMEOUT_EN adds a response watchdog of
// TIMEOUT_CYCLES clock cycles on the waiting states.
module mouse_master_sm #(
   parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
   input  logic       CLK,
   input  logic       RESET,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   output logic       READ_ENABLE,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   input  logic       BYTE_READY,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_DX,
   output logic [7:0] MOUSE_DY,
   output logic       SEND_INTERRUPT,
   output logic       INIT_DONE
);

   localparam int unsigned ST_W   = 4;
   localparam int unsigned BYTE_W = 8;

   localparam logic [ST_W-1:0] S_SEND_FF      = 4'd0;
   localparam logic [ST_W-1:0] S_WAIT_SENT_FF = 4'd1;
   localparam logic [ST_W-1:0] S_WAIT_FA      = 4'd2;
   localparam logic [ST_W-1:0] S_WAIT_AA      = 4'd3;
   localparam logic [ST_W-1:0] S_WAIT_ID      = 4'd4;
   localparam logic [ST_W-1:0] S_SEND_F4      = 4'd5;
   localparam logic [ST_W-1:0] S_WAIT_SENT_F4 = 4'd6;
   localparam logic [ST_W-1:0] S_WAIT_FA2     = 4'd7;
   localparam logic [ST_W-1:0] S_B1           = 4'd8;
   localparam logic [ST_W-1:0] S_B2           = 4'd9;
   localparam logic [ST_W-1:0] S_B3           = 4'd10;
   localparam logic [ST_W-1:0] S_INT          = 4'd11;

   localparam logic [BYTE_W-1:0] CMD_RESET   = 8'hFF;
   localparam logic [BYTE_W-1:0] CMD_ENABLE  = 8'hF4;
   localparam logic [BYTE_W-1:0] RSP_ACK     = 8'hFA;
   localparam logic [BYTE_W-1:0] RSP_BAT_OK  = 8'hAA;
   localparam logic [BYTE_W-1:0] RSP_ID      = 8'h00;
   localparam int unsigned       SYNC_BIT    = 3;

   // Reject a watchdog limit that cannot produce a sensible count
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
      $error("mouse_master_sm: TIMEOUT_CYCLES must be at least 2");
   end

   logic [ST_W-1:0]   state_q;
   logic [ST_W-1:0]   state_nxt;

   logic [BYTE_W-1:0] status_q;
   logic [BYTE_W-1:0] dx_q;
   logic [BYTE_W-1:0] dy_q;
   logic [BYTE_W-1:0] status_nxt;
   logic [BYTE_W-1:0] dx_nxt;
   logic [BYTE_W-1:0] dy_nxt;

   logic              send_byte_nxt;
   logic [BYTE_W-1:0] byte_to_send_nxt;
   logic              read_enable_nxt;
   logic              init_done_nxt;
   logic              send_interrupt_nxt;
   logic [BYTE_W-1:0] mouse_status_nxt;
   logic [BYTE_W-1:0] mouse_dx_nxt;
   logic [BYTE_W-1:0] mouse_dy_nxt;

   logic              good_byte_c;
   logic              bad_byte_c;
   logic              timeout_c;

   // Classify a received byte: any nonzero error code makes it bad
   always_comb begin
      good_byte_c = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
      bad_byte_c  = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
   end

`ifdef MOUSE_RESP_TIMEOUT_EN
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMR_W-1:0] tmr_q;
   logic             tmr_run_c;

   // Watchdog runs only while waiting on the transmitter or the device;
   // S_B1 is left out so an idle mouse does not force a re-init
   always_comb begin
      tmr_run_c = (state_q inside {S_WAIT_SENT_FF, S_WAIT_FA, S_WAIT_AA, S_WAIT_ID,
                                   S_WAIT_SENT_F4, S_WAIT_FA2, S_B2, S_B3});
      timeout_c = tmr_run_c && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
   end

   // Watchdog counter restarts on every state change
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tmr_q <= '0;
      end else if (state_nxt != state_q) begin
         tmr_q <= '0;
      end else if (tmr_run_c) begin
         tmr_q <= tmr_q + TMR_W'(1);
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_SEND_FF;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt          = state_q;
      send_byte_nxt      = 1'b0;
      byte_to_send_nxt   = BYTE_TO_SEND;
      send_interrupt_nxt = 1'b0;
      status_nxt         = status_q;
      dx_nxt             = dx_q;
      dy_nxt             = dy_q;
      mouse_status_nxt   = MOUSE_STATUS;
      mouse_dx_nxt       = MOUSE_DX;
      mouse_dy_nxt       = MOUSE_DY;
      read_enable_nxt    = 1'b0;
      init_done_nxt      = 1'b0;

      case (state_q)
         S_SEND_FF: begin
            send_byte_nxt    = 1'b1;
            byte_to_send_nxt = CMD_RESET;
            state_nxt        = S_WAIT_SENT_FF;
         end
         S_WAIT_SENT_FF: begin
            if (BYTE_SENT) begin
               state_nxt = S_WAIT_FA;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_WAIT_FA: begin
            if (BYTE_READY) begin
               state_nxt = (good_byte_c && (BYTE_READ == RSP_ACK)) ? S_WAIT_AA : S_SEND_FF;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_WAIT_AA: begin
            if (BYTE_READY) begin
               state_nxt = (good_byte_c && (BYTE_READ == RSP_BAT_OK)) ? S_WAIT_ID : S_SEND_FF;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_WAIT_ID: begin
            if (BYTE_READY) begin
               state_nxt = (good_byte_c && (BYTE_READ == RSP_ID)) ? S_SEND_F4 : S_SEND_FF;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_SEND_F4: begin
            send_byte_nxt    = 1'b1;
            byte_to_send_nxt = CMD_ENABLE;
            state_nxt        = S_WAIT_SENT_F4;
         end
         S_WAIT_SENT_F4: begin
            if (BYTE_SENT) begin
               state_nxt = S_WAIT_FA2;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_WAIT_FA2: begin
            if (BYTE_READY) begin
               state_nxt = (good_byte_c && (BYTE_READ == RSP_ACK)) ? S_B1 : S_SEND_FF;
            end else if (timeout_c) begin
               state_nxt = S_SEND_FF;
            end
         end
         S_B1: begin
            // Only a byte with the always-one status bit can start a packet
            if (good_byte_c && BYTE_READ[SYNC_BIT]) begin
               status_nxt = BYTE_READ;
               state_nxt  = S_B2;
            end
         end
         S_B2: begin
            if (good_byte_c) begin
               dx_nxt    = BYTE_READ;
               state_nxt = S_B3;
            end else if (bad_byte_c || timeout_c) begin
               state_nxt = S_B1;
            end
         end
         S_B3: begin
            if (good_byte_c) begin
               dy_nxt    = BYTE_READ;
               state_nxt = S_INT;
            end else if (bad_byte_c || timeout_c) begin
               state_nxt = S_B1;
            end
         end
         S_INT: begin
            mouse_status_nxt   = status_q;
            mouse_dx_nxt       = dx_q;
            mouse_dy_nxt       = dy_q;
            send_interrupt_nxt = 1'b1;
            state_nxt          = S_B1;
         end
         default: begin
            state_nxt = S_SEND_FF;
         end
      endcase

      // Level outputs follow the state being entered so they line up with it
      read_enable_nxt = (state_nxt inside {S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_FA2,
                                           S_B1, S_B2, S_B3, S_INT});
      init_done_nxt   = (state_nxt inside {S_B1, S_B2, S_B3, S_INT});
   end

   // Output and packet holding registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         SEND_BYTE      <= 1'b0;
         BYTE_TO_SEND   <= '0;
         READ_ENABLE    <= 1'b0;
         INIT_DONE      <= 1'b0;
         SEND_INTERRUPT <= 1'b0;
         MOUSE_STATUS   <= '0;
         MOUSE_DX       <= '0;
         MOUSE_DY       <= '0;
         status_q       <= '0;
         dx_q           <= '0;
         dy_q           <= '0;
      end else begin
         SEND_BYTE      <= send_byte_nxt;
         BYTE_TO_SEND   <= byte_to_send_nxt;
         READ_ENABLE    <= read_enable_nxt;
         INIT_DONE      <= init_done_nxt;
         SEND_INTERRUPT <= send_interrupt_nxt;
         MOUSE_STATUS   <= mouse_status_nxt;
         MOUSE_DX       <= mouse_dx_nxt;
         MOUSE_DY       <= mouse_dy_nxt;
         status_q       <= status_nxt;
         dx_q           <= dx_nxt;
         dy_q           <= dy_nxt;
      end
   end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Self-checking bench for mouse_master_sm: random device traffic, a
// protocol-level reference model feeding expectation queues, and a monitor
// that pops and compares on every SEND_BYTE / SEND_INTERRUPT pulse.
module tb_mouse_master_sm;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       SEND_BYTE;
   logic [7:0] BYTE_TO_SEND;
   logic       BYTE_SENT = 1'b0;
   logic       READ_ENABLE;
   logic [7:0] BYTE_READ = 8'h00;
   logic [1:0] BYTE_ERROR_CODE = 2'b00;
   logic       BYTE_READY = 1'b0;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_DX;
   logic [7:0] MOUSE_DY;
   logic       SEND_INTERRUPT;
   logic       INIT_DONE;

   mouse_master_sm #(.TIMEOUT_CYCLES(100)) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .SEND_BYTE       (SEND_BYTE),
      .BYTE_TO_SEND    (BYTE_TO_SEND),
      .BYTE_SENT       (BYTE_SENT),
      .READ_ENABLE     (READ_ENABLE),
      .BYTE_READ       (BYTE_READ),
      .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
      .BYTE_READY      (BYTE_READY),
      .MOUSE_STATUS    (MOUSE_STATUS),
      .MOUSE_DX        (MOUSE_DX),
      .MOUSE_DY        (MOUSE_DY),
      .SEND_INTERRUPT  (SEND_INTERRUPT),
      .INIT_DONE       (INIT_DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: init step (0..3 = expected reply index, 4 = streaming)
   logic [7:0]  init_rsp [4] = '{8'hFA, 8'hAA, 8'h00, 8'hFA};
   int          stage = 0;
   logic [7:0]  pkt[$];
   logic [7:0]  exp_send_q[$];
   logic [23:0] exp_pkt_q[$];
   int          exp_pkt_t[$];
   logic [7:0]  last_exp_send = 8'h00;
   int          last_drive_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      stage = 0;
      pkt.delete();
      exp_send_q.push_back(8'hFF);
   endtask

   // Protocol-level model of one accepted device byte
   task automatic model_rx(input logic [7:0] b, input logic [1:0] e, input int k0,
                           output logic will_send);
      will_send = 1'b0;
      if (stage < 4) begin
         if (e != 2'b00 || b != init_rsp[stage]) begin
            exp_send_q.push_back(8'hFF);
            stage     = 0;
            will_send = 1'b1;
         end else if (stage == 2) begin
            exp_send_q.push_back(8'hF4);
            stage     = 3;
            will_send = 1'b1;
         end else begin
            stage++;
         end
      end else if (e != 2'b00) begin
         pkt.delete();
      end else if (pkt.size() == 0 && !b[3]) begin
         pkt.delete();
      end else begin
         pkt.push_back(b);
         if (pkt.size() == 3) begin
            exp_pkt_q.push_back({pkt[0], pkt[1], pkt[2]});
            exp_pkt_t.push_back(k0 + 2);
            pkt.delete();
         end
      end
   endtask

   // Device byte: wait until the receiver is enabled, injecting ignored noise meanwhile
   task automatic send_rx(input logic [7:0] b, input logic [1:0] e);
      bit   ok;
      logic will;
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(negedge CLK);
         if (READ_ENABLE) begin
            ok = 1'b1;
            break;
         end
         if ($urandom_range(3) == 0) begin
            BYTE_READ       = 8'($urandom);
            BYTE_ERROR_CODE = 2'($urandom);
            BYTE_READY      = 1'b1;
            @(negedge CLK);
            BYTE_READY      = 1'b0;
         end
      end
      check("rx_wait_read_enable", 32'(ok), 32'd1);
      if (!ok) return;
      BYTE_READ       = b;
      BYTE_ERROR_CODE = e;
      BYTE_READY      = 1'b1;
      last_drive_cyc  = cyc;
      model_rx(b, e, cyc, will);
      @(negedge CLK);
      BYTE_READY      = 1'b0;
      BYTE_READ       = 8'($urandom);
      BYTE_ERROR_CODE = 2'b00;
      check("read_enable_after_byte", 32'(READ_ENABLE), 32'(!will));
      check("init_done_after_byte", 32'(INIT_DONE), 32'(stage == 4));
      repeat ($urandom_range(2)) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET      = 1'b1;
      BYTE_READY = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_send_byte", 32'(SEND_BYTE), 32'd0);
      check("rst_byte_to_send", 32'(BYTE_TO_SEND), 32'd0);
      check("rst_read_enable", 32'(READ_ENABLE), 32'd0);
      check("rst_init_done", 32'(INIT_DONE), 32'd0);
      check("rst_interrupt", 32'(SEND_INTERRUPT), 32'd0);
      check("rst_mouse", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'd0);
      model_reset();
      RESET = 1'b0;
   endtask

   task automatic do_init();
      send_rx(8'hFA, 2'b00);
      send_rx(8'hAA, 2'b00);
      send_rx(8'h00, 2'b00);
      send_rx(8'hFA, 2'b00);
   endtask

   // Transmitter stand-in: acknowledge each SEND_BYTE, plus stray BYTE_SENT while streaming
   initial begin
      bit busy;
      int cnt;
      busy = 1'b0;
      cnt  = 0;
      forever begin
         @(negedge CLK);
         BYTE_SENT = 1'b0;
         if (RESET) begin
            busy = 1'b0;
         end else if (busy) begin
            if (cnt == 0) begin
               check("byte_to_send_held", 32'(BYTE_TO_SEND), 32'(last_exp_send));
               BYTE_SENT = 1'b1;
               busy      = 1'b0;
            end else begin
               cnt--;
            end
         end else if (SEND_BYTE) begin
            busy = 1'b1;
            cnt  = int'($urandom_range(3));
         end else if (INIT_DONE && $urandom_range(15) == 0) begin
            BYTE_SENT = 1'b1;
         end
      end
   end

   // Monitor: pop and compare on every DUT output event
   initial begin
      logic        prev_sb;
      logic [23:0] last_pkt;
      prev_sb  = 1'b0;
      last_pkt = 24'h0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            prev_sb  = 1'b0;
            last_pkt = 24'h0;
            continue;
         end
         if (SEND_BYTE) begin
            check("send_byte_single_cycle", 32'(prev_sb), 32'd0);
            if (exp_send_q.size() == 0) begin
               check("send_byte_unexpected", 32'(exp_send_q.size()), 32'd1);
            end else begin
               last_exp_send = exp_send_q.pop_front();
               check("send_byte_value", 32'(BYTE_TO_SEND), 32'(last_exp_send));
            end
         end
         prev_sb = SEND_BYTE;
         if (SEND_INTERRUPT) begin
            if (exp_pkt_q.size() == 0) begin
               check("interrupt_unexpected", 32'(exp_pkt_q.size()), 32'd1);
            end else begin
               int t;
               last_pkt = exp_pkt_q.pop_front();
               t        = exp_pkt_t.pop_front();
               check("packet_value", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'(last_pkt));
               check("interrupt_latency", 32'(cyc), 32'(t));
            end
         end else begin
            check("mouse_outputs_hold", 32'({MOUSE_STATUS, MOUSE_DX, MOUSE_DY}), 32'(last_pkt));
         end
      end
   end

   // Stimulus sequence
   initial begin
      logic [7:0] b;
      logic [1:0] e;

      do_reset();
      do_init();
      check("init_done_streaming", 32'(INIT_DONE), 32'd1);

      // nominal packet
      send_rx(8'h09, 2'b00);
      send_rx(8'h05, 2'b00);
      send_rx(8'hFB, 2'b00);

      // resync: bit3 clear is dropped in the first slot
      send_rx(8'h05, 2'b00);
      send_rx(8'h08, 2'b00);
      send_rx(8'h01, 2'b00);
      send_rx(8'h02, 2'b00);

      // stop-bit error discards partial packet
      send_rx(8'h08, 2'b00);
      send_rx(8'h33, 2'b10);
      send_rx(8'h18, 2'b00);
      send_rx(8'h7F, 2'b00);
      send_rx(8'h80, 2'b00);

      // reset in the middle of a packet
      send_rx(8'h08, 2'b00);
      send_rx(8'h01, 2'b00);
      do_reset();

      // init errors: wrong reply, then parity error on self-test byte
      send_rx(8'hFE, 2'b00);
      send_rx(8'hFA, 2'b00);
      send_rx(8'hAA, 2'b01);
      do_init();

      // random streaming traffic with occasional errors and desync bytes
      for (int i = 0; i < 90; i++) begin
         b = 8'($urandom);
         if ($urandom_range(2) != 0) b[3] = 1'b1;
         e = ($urandom_range(9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         send_rx(b, e);
      end

`ifdef MOUSE_RESP_TIMEOUT_EN
      // silence in S_WAIT_AA: 100 cycles there, then S_SEND_FF, then the pulse
      do_reset();
      send_rx(8'hFA, 2'b00);
      exp_send_q.push_back(8'hFF);
      stage = 0;
      for (int n = 0; n < 200; n++) begin
         if (SEND_BYTE) break;
         @(negedge CLK);
      end
      check("timeout_resend_cycle", 32'(cyc - last_drive_cyc), 32'd102);
      do_init();
      send_rx(8'h28, 2'b00);
      send_rx(8'h11, 2'b00);
      send_rx(8'hEE, 2'b00);
`endif

      repeat (20) @(negedge CLK);
      check("pending_sends", 32'(exp_send_q.size()), 32'd0);
      check("pending_packets", 32'(exp_pkt_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "simulation time bound reached");
   end

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
- Controller sequencing the PS/2 mouse link: drives the host-to-device byte transmitter and consumes bytes from the device-to-host receiver.
- Runs the power-up handshake (reset, self-test, ID, enable streaming), then parses 3-byte movement packets.
- Presents status and movement to the processor bus with a one-cycle interrupt pulse per packet.

Parameters:
- TIMEOUT_CYCLES, 5000000, response watchdog limit in CLK cycles (100 ms at 50 MHz); used only with the optional feature.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous active-high reset
- SEND_BYTE  out  1  one-cycle request to the transmitter
- BYTE_TO_SEND  out  8  command byte; held stable from the SEND_BYTE pulse until BYTE_SENT
- BYTE_SENT  in  1  one-cycle pulse from the transmitter: frame complete and device acknowledged
- READ_ENABLE  out  1  enables the receiver
- BYTE_READ  in  8  received byte; valid when BYTE_READY=1
- BYTE_ERROR_CODE  in  2  receiver error: bit0 parity, bit1 stop; valid with BYTE_READY
- BYTE_READY  in  1  one-cycle pulse: received byte valid
- MOUSE_STATUS  out  8  last packet byte 1
- MOUSE_DX  out  8  last packet byte 2, raw two's complement
- MOUSE_DY  out  8  last packet byte 3, raw two's complement
- SEND_INTERRUPT  out  1  one-cycle pulse: new packet latched
- INIT_DONE  out  1  high while in streaming mode

Behaviour:
- Reset values:
  - All outputs 0.
  - State = S_SEND_FF.
  - Internal packet holding registers 0.
- All state and outputs are registered.
- Receive-byte acceptance: in any state, a BYTE_READY pulse with BYTE_ERROR_CODE != 0 is treated as a bad byte.
- States and transitions:
  - S_SEND_FF: BYTE_TO_SEND=0xFF; pulse SEND_BYTE for exactly 1 cycle; go to S_WAIT_SENT_FF.
  - S_WAIT_SENT_FF: on BYTE_SENT go to S_WAIT_FA.
  - S_WAIT_FA: on good byte 0xFA go to S_WAIT_AA.
  - S_WAIT_AA: on good byte 0xAA go to S_WAIT_ID.
  - S_WAIT_ID: on good byte 0x00 go to S_SEND_F4.
  - S_SEND_F4: BYTE_TO_SEND=0xF4; 1-cycle SEND_BYTE; go to S_WAIT_SENT_F4.
  - S_WAIT_SENT_F4: on BYTE_SENT go to S_WAIT_FA2.
  - S_WAIT_FA2: on good byte 0xFA go to S_B1.
  - S_B1: wait for a good byte with bit3=1; store as status, go to S_B2. A good byte with bit3=0 is discarded and the state stays S_B1 (resync).
  - S_B2: good byte stored as dx, go to S_B3.
  - S_B3: good byte stored as dy, go to S_INT.
  - S_INT: one cycle. Copy status/dx/dy to MOUSE_STATUS/DX/DY, assert SEND_INTERRUPT=1, go to S_B1.
- Error and mismatch handling:
  - Init states (S_WAIT_FA, S_WAIT_AA, S_WAIT_ID, S_WAIT_FA2): a bad byte or a good byte with the wrong value returns to S_SEND_FF (full re-init, INIT_DONE=0).
  - Streaming states (S_B1/S_B2/S_B3): a bad byte discards the partial packet and returns to S_B1. Outputs keep the last good packet.
- Output timing:
  - MOUSE_* and SEND_INTERRUPT update on the edge after the state enters S_INT, i.e. 2 cycles after the BYTE_READY of byte 3.
  - MOUSE_* outputs change only in S_INT.
- READ_ENABLE: 1 in every S_WAIT_FA/AA/ID/FA2 and S_B1..S_INT state; 0 in S_SEND_* and S_WAIT_SENT_* states.
- INIT_DONE: 1 in S_B1..S_INT; 0 otherwise.
- Simultaneous events:
  - BYTE_READY arriving in a send or wait-sent state is ignored.
  - BYTE_SENT arriving outside the wait-sent states is ignored.
- Mid-operation reset: returns to S_SEND_FF on the next edge. Outputs clear; SEND_BYTE is never left asserted.

Optional Feature:
- Macro: MOUSE_RESP_TIMEOUT_EN.
- With the macro:
  - A counter clears on every state change and increments in every S_WAIT_* state.
  - On reaching TIMEOUT_CYCLES-1 without a transition, go to S_SEND_FF.
  - The streaming states S_B1..S_B3 are excluded; S_B2/S_B3 instead time out to S_B1.
- Without the macro: no counter; wait states wait indefinitely.

Test Plan:
- Nominal init: BYTE_SENT after 0xFF, then bytes 0xFA, 0xAA, 0x00 -> SEND_BYTE with 0xF4. After BYTE_SENT and 0xFA -> INIT_DONE=1.
- Packet: stream bytes 0x09, 0x05, 0xFB -> 2 cycles after the third BYTE_READY: SEND_INTERRUPT=1 for 1 cycle, MOUSE_STATUS=0x09, DX=0x05, DY=0xFB.
- Resync: in S_B1 send 0x05 (bit3=0), then 0x08, 0x01, 0x02 -> one interrupt, STATUS=0x08, DX=0x01, DY=0x02.
- Init error: reply 0xFE instead of 0xFA -> a new SEND_BYTE with 0xFF. A parity error (code 01) on byte 0xAA -> re-init.
- Stream error: bytes 0x08, then error code 10 -> no interrupt; the next 0x18, 0x7F, 0x80 -> STATUS=0x18, DX=0x7F, DY=0x80.
- Reset mid-packet after 2 bytes -> all outputs 0, SEND_BYTE pulses 0xFF on restart. With MOUSE_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=100, silence in S_WAIT_AA -> re-send 0xFF after 100 cycles.
